// File: rtl/core_pipe_hcu_pkg.sv
// Shared definitions for the pipeline hazard/control unit: FSM encodings,
// forward-select constants and tracker entry field widths.
package core_pipe_hcu_pkg;

  typedef enum logic [0:0] {
    HCU_RUN     = 1'b0,
    HCU_MEMWAIT = 1'b1
  } hcu_state_t;

  localparam int FWD_SEL_REGFILE = 0;

  localparam int ENTRY_VALID_W = 1;
  localparam int ENTRY_LOAD_W  = 1;

  // A load's data is captured by the time it reaches pipeline register 2,
  // so only a load still sitting in register 1 cannot be forwarded yet.
  localparam int LOAD_READY_K = 2;

  function automatic int entry_width(input int reg_aw);
    return ENTRY_VALID_W + reg_aw + ENTRY_LOAD_W;
  endfunction

endpackage

// File: rtl/core_pipe_hcu_tracker.sv
// Destination-register tracker: one entry per pipeline register 1..NUM_STAGES-2
// plus a per-read-port nearest-match priority encoder.
module core_hcu_tracker
  import core_pipe_hcu_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int NUM_RPORTS = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_W      = 2
) (
  input  logic                         CLK,
  input  logic                         NRST,
  input  logic [NUM_RPORTS*REG_AW-1:0] id_raddr,
  input  logic [NUM_RPORTS-1:0]        id_rvalid,
  input  logic [REG_AW-1:0]            id_waddr,
  input  logic                         id_wvalid,
  input  logic                         id_isload,
  input  logic [NUM_STAGES-3:0]        stage_write,
  input  logic [NUM_STAGES-3:0]        stage_flush,
  output logic [NUM_RPORTS-1:0]        match_any,
  output logic [NUM_RPORTS-1:0]        match_load,
  output logic [NUM_RPORTS*FWD_W-1:0]  match_k
);

  localparam int NT = NUM_STAGES - 2;

  logic              ent_valid [1:NT];
  logic [REG_AW-1:0] ent_addr  [1:NT];
  logic              ent_load  [1:NT];

  // Entry k follows pipeline register k; stage_write/stage_flush bit k-1 belong to entry k.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int k = 1; k <= NT; k++) begin
        ent_valid[k] <= 1'b0;
        ent_addr[k]  <= '0;
        ent_load[k]  <= 1'b0;
      end
    end else begin
      if (stage_flush[0]) begin
        ent_valid[1] <= 1'b0;
        ent_addr[1]  <= '0;
        ent_load[1]  <= 1'b0;
      end else if (stage_write[0]) begin
        ent_valid[1] <= id_wvalid;
        ent_addr[1]  <= id_waddr;
        ent_load[1]  <= id_isload;
      end
      for (int k = 2; k <= NT; k++) begin
        if (stage_flush[k-1]) begin
          ent_valid[k] <= 1'b0;
          ent_addr[k]  <= '0;
          ent_load[k]  <= 1'b0;
        end else if (stage_write[k-1]) begin
          ent_valid[k] <= ent_valid[k-1];
          ent_addr[k]  <= ent_addr[k-1];
          ent_load[k]  <= ent_load[k-1];
        end
      end
    end
  end

  // Scan from the oldest entry down so the youngest (lowest k) match is the one left standing.
  always_comb begin
    match_any  = '0;
    match_load = '0;
    match_k    = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      for (int k = NT; k >= 1; k--) begin
        if (id_rvalid[p] && (id_raddr[p*REG_AW +: REG_AW] != '0) && ent_valid[k] &&
            (ent_addr[k] == id_raddr[p*REG_AW +: REG_AW])) begin
          match_any[p]                = 1'b1;
          match_load[p]               = ent_load[k];
          match_k[p*FWD_W +: FWD_W]   = FWD_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/core_pipe_hcu.sv
// Hazard/control unit: memory-wait FSM, redirect/data-stall priority and forward selects.
// Optional feature: define CORE_HCU_FWD_EN to enable operand forwarding.
module core_pipe_hcu
  import core_pipe_hcu_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int NUM_RPORTS = 2,
  parameter int REG_AW     = 5,
  localparam int FWD_W     = $clog2(NUM_STAGES-1)
) (
  input  logic                         CLK,
  input  logic                         NRST,
  input  logic [NUM_RPORTS*REG_AW-1:0] ID_RADDR,
  input  logic [NUM_RPORTS-1:0]        ID_RVALID,
  input  logic [REG_AW-1:0]            ID_WADDR,
  input  logic                         ID_WVALID,
  input  logic                         ID_ISLOAD,
  input  logic                         EX_REDIRECT,
  input  logic                         IMEM_BUSY,
  input  logic                         IMEM_DONE,
  input  logic                         DMEM_BUSY,
  input  logic                         DMEM_DONE,
  output logic [NUM_STAGES-2:0]        STAGE_WRITE,
  output logic [NUM_STAGES-2:0]        STAGE_FLUSH,
  output logic                         PC_WRITE,
  output logic [NUM_RPORTS*FWD_W-1:0]  FWD_SEL
);

  hcu_state_t state, state_nxt;
  logic imem_done_q, imem_done_nxt;
  logic dmem_done_q, dmem_done_nxt;
  logic pend;
  logic data_stall;

  logic [NUM_RPORTS-1:0]       match_any;
  logic [NUM_RPORTS-1:0]       match_load;
  logic [NUM_RPORTS*FWD_W-1:0] match_k;
  logic [NUM_RPORTS*FWD_W-1:0] fwd_raw;

  core_hcu_tracker #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_RPORTS (NUM_RPORTS),
    .REG_AW     (REG_AW),
    .FWD_W      (FWD_W)
  ) u_tracker (
    .CLK         (CLK),
    .NRST        (NRST),
    .id_raddr    (ID_RADDR),
    .id_rvalid   (ID_RVALID),
    .id_waddr    (ID_WADDR),
    .id_wvalid   (ID_WVALID),
    .id_isload   (ID_ISLOAD),
    .stage_write (STAGE_WRITE[NUM_STAGES-2:1]),
    .stage_flush (STAGE_FLUSH[NUM_STAGES-2:1]),
    .match_any   (match_any),
    .match_load  (match_load),
    .match_k     (match_k)
  );

  assign pend = (IMEM_BUSY & ~IMEM_DONE & ~imem_done_q) |
                (DMEM_BUSY & ~DMEM_DONE & ~dmem_done_q);

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state       <= HCU_RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      imem_done_q <= imem_done_nxt;
      dmem_done_q <= dmem_done_nxt;
    end
  end

  // A DONE only counts while its BUSY is high; stray pulses are dropped.
  always_comb begin
    state_nxt     = state;
    imem_done_nxt = imem_done_q;
    dmem_done_nxt = dmem_done_q;
    case (state)
      HCU_RUN: begin
        if (pend) begin
          state_nxt     = HCU_MEMWAIT;
          imem_done_nxt = imem_done_q | (IMEM_BUSY & IMEM_DONE);
          dmem_done_nxt = dmem_done_q | (DMEM_BUSY & DMEM_DONE);
        end
      end
      HCU_MEMWAIT: begin
        if (!pend) begin
          state_nxt     = HCU_RUN;
          imem_done_nxt = 1'b0;
          dmem_done_nxt = 1'b0;
        end else begin
          imem_done_nxt = imem_done_q | (IMEM_BUSY & IMEM_DONE);
          dmem_done_nxt = dmem_done_q | (DMEM_BUSY & DMEM_DONE);
        end
      end
      default: state_nxt = HCU_RUN;
    endcase
  end

`ifdef CORE_HCU_FWD_EN
  always_comb begin
    data_stall = 1'b0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (match_any[p] && match_load[p] &&
          (int'(match_k[p*FWD_W +: FWD_W]) < LOAD_READY_K)) begin
        data_stall = 1'b1;
      end
    end
  end

  assign fwd_raw = match_k;
`else
  logic unused_match;

  assign unused_match = ^{match_load, match_k};
  assign data_stall   = |match_any;
  assign fwd_raw      = {(NUM_RPORTS*FWD_W){1'b0}} | FWD_SEL_REGFILE[0];
`endif

  // Reset forcing, then memory freeze, redirect, data stall, normal advance.
  always_comb begin
    STAGE_WRITE = '1;
    STAGE_FLUSH = '0;
    PC_WRITE    = 1'b1;
    FWD_SEL     = fwd_raw;
    if (!NRST) begin
      STAGE_WRITE = '0;
      STAGE_FLUSH = '1;
      PC_WRITE    = 1'b0;
      FWD_SEL     = '0;
    end else if (pend) begin
      STAGE_WRITE = '0;
      PC_WRITE    = 1'b0;
    end else if (EX_REDIRECT) begin
      STAGE_FLUSH[1:0] = 2'b11;
    end else if (data_stall) begin
      STAGE_WRITE[0] = 1'b0;
      STAGE_FLUSH[1] = 1'b1;
      PC_WRITE       = 1'b0;
    end
  end

endmodule

// File: tb/tb_core_pipe_hcu.sv
// Directed scoreboard bench for core_pipe_hcu (default parameters).
module tb_core_pipe_hcu;

  localparam int NS = 5;
  localparam int NP = 2;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic [NP*AW-1:0] ID_RADDR = '0;
  logic [NP-1:0] ID_RVALID = '0;
  logic [AW-1:0] ID_WADDR = '0;
  logic          ID_WVALID = 1'b0;
  logic          ID_ISLOAD = 1'b0;
  logic          EX_REDIRECT = 1'b0;
  logic          IMEM_BUSY = 1'b0;
  logic          IMEM_DONE = 1'b0;
  logic          DMEM_BUSY = 1'b0;
  logic          DMEM_DONE = 1'b0;
  logic [NS-2:0] STAGE_WRITE;
  logic [NS-2:0] STAGE_FLUSH;
  logic          PC_WRITE;
  logic [3:0]    FWD_SEL;

  core_pipe_hcu #(.NUM_STAGES(NS), .NUM_RPORTS(NP), .REG_AW(AW)) dut (
    .CLK(CLK), .NRST(NRST),
    .ID_RADDR(ID_RADDR), .ID_RVALID(ID_RVALID),
    .ID_WADDR(ID_WADDR), .ID_WVALID(ID_WVALID), .ID_ISLOAD(ID_ISLOAD),
    .EX_REDIRECT(EX_REDIRECT),
    .IMEM_BUSY(IMEM_BUSY), .IMEM_DONE(IMEM_DONE),
    .DMEM_BUSY(DMEM_BUSY), .DMEM_DONE(DMEM_DONE),
    .STAGE_WRITE(STAGE_WRITE), .STAGE_FLUSH(STAGE_FLUSH),
    .PC_WRITE(PC_WRITE), .FWD_SEL(FWD_SEL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] wr;
    logic [3:0] wm;
    logic [3:0] fl;
    logic       pc;
    logic [3:0] fwd;
    logic [3:0] fm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic setId(input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] rv,
                       input logic [4:0] wa, input logic wv, input logic ld);
    @(negedge CLK);
    ID_RADDR  = {ra1, ra0};
    ID_RVALID = rv;
    ID_WADDR  = wa;
    ID_WVALID = wv;
    ID_ISLOAD = ld;
  endtask

  task automatic setMem(input logic redir, input logic ib, input logic idn,
                        input logic db, input logic ddn);
    EX_REDIRECT = redir;
    IMEM_BUSY   = ib;
    IMEM_DONE   = idn;
    DMEM_BUSY   = db;
    DMEM_DONE   = ddn;
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ((STAGE_WRITE & e.wm) === (e.wr & e.wm)) else begin
      errors++;
      $error("[TB] FAIL %s write: got %b want %b (mask %b)", e.tag, STAGE_WRITE, e.wr, e.wm);
    end
    checks++;
    assert (STAGE_FLUSH === e.fl) else begin
      errors++;
      $error("[TB] FAIL %s flush: got %b want %b", e.tag, STAGE_FLUSH, e.fl);
    end
    checks++;
    assert (PC_WRITE === e.pc) else begin
      errors++;
      $error("[TB] FAIL %s pc_write: got %b want %b", e.tag, PC_WRITE, e.pc);
    end
    checks++;
    assert ((FWD_SEL & e.fm) === (e.fwd & e.fm)) else begin
      errors++;
      $error("[TB] FAIL %s fwd_sel: got %b want %b (mask %b)", e.tag, FWD_SEL, e.fwd, e.fm);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] wr, input logic [3:0] wm,
                               input logic [3:0] fl, input logic pc,
                               input logic [3:0] fwd, input logic [3:0] fm);
    exp_t e;
    e.tag = tag; e.wr = wr; e.wm = wm; e.fl = fl; e.pc = pc; e.fwd = fwd; e.fm = fm;
    sb.push_back(e);
    #2;
    checkOutput();
  endtask

  task automatic expNorm(input string tag, input logic [3:0] fwd);
    applyStimulus(tag, 4'b1111, 4'b1111, 4'b0000, 1'b1, fwd, 4'b1111);
  endtask

  task automatic expFreeze(input string tag);
    applyStimulus(tag, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111);
  endtask

  task automatic expDstall(input string tag, input logic [3:0] fm);
    applyStimulus(tag, 4'b1110, 4'b1111, 4'b0010, 1'b0, 4'b0000, fm);
  endtask

  task automatic expRedir(input string tag);
    applyStimulus(tag, 4'b1100, 4'b1100, 4'b0011, 1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic expReset(input string tag);
    applyStimulus(tag, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b1111);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
      setMem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expNorm("drain", 4'b0000);
    end
  endtask

  initial begin
    // Reset state
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    expReset("reset_a");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    expReset("reset_b");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    NRST = 1'b1;
    expNorm("rst_release", 4'b0000);

    // Back-to-back ALU dependency: addi x5 ; add x6,x5,x5
    setId(0, 0, 2'b01, 5, 1'b1, 1'b0);
    expNorm("alu_prod", 4'b0000);
`ifdef CORE_HCU_FWD_EN
    setId(5, 5, 2'b11, 6, 1'b1, 1'b0);
    expNorm("alu_fwd", 4'b0101);
`else
    for (int i = 0; i < 3; i++) begin
      setId(5, 5, 2'b11, 6, 1'b1, 1'b0);
      expDstall($sformatf("alu_stall%0d", i + 1), 4'b1111);
    end
    setId(5, 5, 2'b11, 6, 1'b1, 1'b0);
    expNorm("alu_clear", 4'b0000);
`endif
    drain();

    // Load-use: lw x7 ; addi x8,x7,1
    setId(2, 0, 2'b01, 7, 1'b1, 1'b1);
    expNorm("lw_issue", 4'b0000);
`ifdef CORE_HCU_FWD_EN
    setId(7, 0, 2'b01, 8, 1'b1, 1'b0);
    expDstall("lu_stall", 4'b0000);
    setId(7, 0, 2'b01, 8, 1'b1, 1'b0);
    expNorm("lu_fwd", 4'b0010);
`else
    for (int i = 0; i < 3; i++) begin
      setId(7, 0, 2'b01, 8, 1'b1, 1'b0);
      expDstall($sformatf("lu_stall%0d", i + 1), 4'b1111);
    end
    setId(7, 0, 2'b01, 8, 1'b1, 1'b0);
    expNorm("lu_clear", 4'b0000);
`endif
    drain();

    // x0 destination never creates a hazard
    setId(0, 0, 2'b01, 0, 1'b1, 1'b0);
    expNorm("x0_prod", 4'b0000);
    setId(0, 0, 2'b11, 1, 1'b1, 1'b0);
    expNorm("x0_use", 4'b0000);
    drain();

    // DMEM wait: busy 4 cycles, done on the 4th
    for (int i = 0; i < 3; i++) begin
      setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
      setMem(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expFreeze($sformatf("dmem_wait%0d", i + 1));
    end
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expNorm("dmem_release", 4'b0000);
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expNorm("dmem_idle", 4'b0000);

    // IMEM done at cycle 2, DMEM done at cycle 5
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expFreeze("dual_c1");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expFreeze("dual_c2");
    for (int i = 3; i <= 4; i++) begin
      setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
      setMem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      expFreeze($sformatf("dual_c%0d", i));
    end
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expNorm("dual_release", 4'b0000);
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expFreeze("flags_cleared");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expNorm("imem_release", 4'b0000);

    // DONE with BUSY low must not be remembered
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expNorm("done_no_busy", 4'b0000);
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expFreeze("done_ignored");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expNorm("done_release", 4'b0000);
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expNorm("mem_idle", 4'b0000);

    // Redirect beats a load-use hazard
    setId(2, 0, 2'b01, 7, 1'b1, 1'b1);
    expNorm("lw_issue2", 4'b0000);
    setId(7, 0, 2'b01, 8, 1'b1, 1'b0);
    setMem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expRedir("redir_lu");
    drain();

    // Redirect held through a memory freeze
    for (int i = 0; i < 2; i++) begin
      setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
      setMem(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      expFreeze($sformatf("redir_frozen%0d", i + 1));
    end
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expRedir("redir_release");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expNorm("redir_done", 4'b0000);

    // Reset in the middle of a memory wait
    setId(0, 0, 2'b01, 5, 1'b1, 1'b0);
    expNorm("rst_prod", 4'b0000);
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expFreeze("rst_wait1");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    setMem(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expFreeze("rst_wait2");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    NRST = 1'b0;
    setMem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expReset("rst_mid");
    setId(0, 0, 2'b00, 0, 1'b0, 1'b0);
    NRST = 1'b1;
    setMem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expFreeze("rst_flag_clear");
    setId(5, 0, 2'b01, 9, 1'b1, 1'b0);
    setMem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expNorm("rst_tracker_empty", 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
